// File: rtl/qspi_inst_decode_if.sv
// Request/response and sequencer-descriptor signals between arbiter, decoder and sequencer.
interface qspi_inst_decode_if;
    logic        io_flash_req_valid;
    logic        io_flash_req_ready;
    logic [7:0]  io_flash_req_inst;
    logic        io_flash_req_inst_label;
    logic [7:0]  io_flash_req_data_size;
    logic [7:0]  io_flash_req_data_burstlen;
    logic [23:0] io_flash_req_addr;
    logic        io_flash_resp_valid;
    logic        io_flash_resp_error;
    logic [1:0]  io_flash_resp_cause;
    logic        io_tran_inst_label;
    logic        io_seq_start;
    logic [7:0]  io_seq_inst;
    logic [23:0] io_seq_addr;
    logic        io_seq_addr_en;
    logic [3:0]  io_seq_dummy;
    logic [1:0]  io_seq_lanes;
    logic        io_seq_dir;
    logic [15:0] io_seq_byte_cnt;
    logic        io_seq_done;

    modport slave (
        input  io_flash_req_valid, io_flash_req_inst, io_flash_req_inst_label,
               io_flash_req_data_size, io_flash_req_data_burstlen, io_flash_req_addr,
               io_seq_done,
        output io_flash_req_ready, io_flash_resp_valid, io_flash_resp_error,
               io_flash_resp_cause, io_tran_inst_label, io_seq_start, io_seq_inst,
               io_seq_addr, io_seq_addr_en, io_seq_dummy, io_seq_lanes, io_seq_dir,
               io_seq_byte_cnt
    );

    modport master (
        output io_flash_req_valid, io_flash_req_inst, io_flash_req_inst_label,
               io_flash_req_data_size, io_flash_req_data_burstlen, io_flash_req_addr,
               io_seq_done,
        input  io_flash_req_ready, io_flash_resp_valid, io_flash_resp_error,
               io_flash_resp_cause, io_tran_inst_label, io_seq_start, io_seq_inst,
               io_seq_addr, io_seq_addr_en, io_seq_dummy, io_seq_lanes, io_seq_dir,
               io_seq_byte_cnt
    );
endinterface

// File: rtl/qspi_inst_decode.sv
// QSPI decode-and-issue stage: validates one flash request, issues a sequencer
// descriptor for legal ones, tracks write-enable latch, returns one response each.
module qspi_inst_decode #(
    parameter int unsigned PAGE_BYTES = 256,
    parameter int unsigned FAST_DUMMY = 8
) (
    input logic               clock,
    input logic               rst_n,
    qspi_inst_decode_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [7:0]  inst_q, inst_d, size_q, size_d, burst_q, burst_d;
    logic [23:0] addr_q, addr_d;
    logic        label_q, label_d, wel_q, wel_d;

    logic        ready_q, ready_d, resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
    logic [1:0]  resp_cause_q, resp_cause_d;
    logic        tran_label_q, tran_label_d, start_q, start_d;
    logic [7:0]  seq_inst_q, seq_inst_d;
    logic [23:0] seq_addr_q, seq_addr_d;
    logic        seq_addr_en_q, seq_addr_en_d, seq_dir_q, seq_dir_d;
    logic [3:0]  seq_dummy_q, seq_dummy_d;
    logic [1:0]  seq_lanes_q, seq_lanes_d;
    logic [15:0] seq_byte_cnt_q, seq_byte_cnt_d;

    logic        known, addr_en, dir, has_data, x4, needs_wel, prog, clears_wel, size_ok;
    logic [3:0]  dummy;
    logic [15:0] byte_cnt;
    logic [16:0] page_end;
    logic [1:0]  cause;

    // Opcode table lookup and rule checks on the latched request
    always_comb begin
        known      = 1'b1;
        addr_en    = 1'b1;
        dir        = 1'b0;
        has_data   = 1'b1;
        x4         = 1'b0;
        needs_wel  = 1'b0;
        prog       = 1'b0;
        clears_wel = 1'b0;
        dummy      = 4'd0;
        case (inst_q)
            8'h03: ;
            8'h0B: dummy = 4'(FAST_DUMMY);
            8'h6B: begin dummy = 4'(FAST_DUMMY); x4 = 1'b1; end
            8'h9F, 8'h05: addr_en = 1'b0;
            8'h02: begin dir = 1'b1; needs_wel = 1'b1; prog = 1'b1; clears_wel = 1'b1; end
            8'h32: begin dir = 1'b1; needs_wel = 1'b1; prog = 1'b1; clears_wel = 1'b1; x4 = 1'b1; end
            8'h20, 8'hD8: begin dir = 1'b1; has_data = 1'b0; needs_wel = 1'b1; clears_wel = 1'b1; end
            8'h06: begin addr_en = 1'b0; dir = 1'b1; has_data = 1'b0; end
            8'h04: begin addr_en = 1'b0; dir = 1'b1; has_data = 1'b0; clears_wel = 1'b1; end
            default: known = 1'b0;
        endcase
        byte_cnt = has_data ? 16'(size_q) * (16'(burst_q) + 16'd1) : 16'd0;
        size_ok  = (size_q == 8'd1) || (size_q == 8'd2) || (size_q == 8'd4);
        page_end = 17'(addr_q & 24'(PAGE_BYTES - 1)) + 17'(byte_cnt);
        if (!known)
            cause = 2'b01;
        else if (has_data && !size_ok)
            cause = 2'b10;
        else if ((needs_wel && !wel_q) || (prog && (page_end > 17'(PAGE_BYTES))))
            cause = 2'b11;
        else
            cause = 2'b00;
    end

    // Next-state, request latching, WEL tracking and registered-output inputs
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        size_d  = size_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        label_d = label_q;
        wel_d   = wel_q;
        case (state_q)
            IDLE: begin
                if (bus.io_flash_req_valid && ready_q) begin
                    state_d = CHECK;
                    inst_d  = bus.io_flash_req_inst;
                    size_d  = bus.io_flash_req_data_size;
                    burst_d = bus.io_flash_req_data_burstlen;
                    addr_d  = bus.io_flash_req_addr;
                    label_d = bus.io_flash_req_inst_label;
                end
            end
            CHECK: state_d = (cause != 2'b00) ? RESP : ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.io_seq_done) begin
                    state_d = RESP;
                    if (inst_q == 8'h06)
                        wel_d = 1'b1;
                    else if (clears_wel)
                        wel_d = 1'b0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d      = (state_d == IDLE);
        start_d      = (state_d == ISSUE);
        resp_valid_d = (state_d == RESP);
        resp_error_d = (state_q == CHECK) && (state_d == RESP);
        resp_cause_d = resp_error_d ? cause : 2'b00;
        tran_label_d = (state_d == IDLE) ? 1'b0 : label_d;

        // Descriptor is driven only while the sequencer owns the transfer
        if ((state_d == ISSUE) || (state_d == WAIT)) begin
            seq_inst_d     = inst_q;
            seq_addr_d     = addr_q;
            seq_addr_en_d  = addr_en;
            seq_dummy_d    = dummy;
            seq_lanes_d    = x4 ? 2'b11 : 2'b01;
            seq_dir_d      = dir;
            seq_byte_cnt_d = byte_cnt;
        end else begin
            seq_inst_d     = 8'd0;
            seq_addr_d     = 24'd0;
            seq_addr_en_d  = 1'b0;
            seq_dummy_d    = 4'd0;
            seq_lanes_d    = 2'b00;
            seq_dir_d      = 1'b0;
            seq_byte_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            inst_q         <= 8'd0;
            size_q         <= 8'd0;
            burst_q        <= 8'd0;
            addr_q         <= 24'd0;
            label_q        <= 1'b0;
            wel_q          <= 1'b0;
            ready_q        <= 1'b1;
            start_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_error_q   <= 1'b0;
            resp_cause_q   <= 2'b00;
            tran_label_q   <= 1'b0;
            seq_inst_q     <= 8'd0;
            seq_addr_q     <= 24'd0;
            seq_addr_en_q  <= 1'b0;
            seq_dummy_q    <= 4'd0;
            seq_lanes_q    <= 2'b00;
            seq_dir_q      <= 1'b0;
            seq_byte_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            inst_q         <= inst_d;
            size_q         <= size_d;
            burst_q        <= burst_d;
            addr_q         <= addr_d;
            label_q        <= label_d;
            wel_q          <= wel_d;
            ready_q        <= ready_d;
            start_q        <= start_d;
            resp_valid_q   <= resp_valid_d;
            resp_error_q   <= resp_error_d;
            resp_cause_q   <= resp_cause_d;
            tran_label_q   <= tran_label_d;
            seq_inst_q     <= seq_inst_d;
            seq_addr_q     <= seq_addr_d;
            seq_addr_en_q  <= seq_addr_en_d;
            seq_dummy_q    <= seq_dummy_d;
            seq_lanes_q    <= seq_lanes_d;
            seq_dir_q      <= seq_dir_d;
            seq_byte_cnt_q <= seq_byte_cnt_d;
        end
    end

    assign bus.io_flash_req_ready  = ready_q;
    assign bus.io_flash_resp_valid = resp_valid_q;
    assign bus.io_flash_resp_error = resp_error_q;
    assign bus.io_flash_resp_cause = resp_cause_q;
    assign bus.io_tran_inst_label  = tran_label_q;
    assign bus.io_seq_start        = start_q;
    assign bus.io_seq_inst         = seq_inst_q;
    assign bus.io_seq_addr         = seq_addr_q;
    assign bus.io_seq_addr_en      = seq_addr_en_q;
    assign bus.io_seq_dummy        = seq_dummy_q;
    assign bus.io_seq_lanes        = seq_lanes_q;
    assign bus.io_seq_dir          = seq_dir_q;
    assign bus.io_seq_byte_cnt     = seq_byte_cnt_q;
endmodule
